// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single outstanding request to instruction memory,
// one-entry skid buffer for IF/ID back-pressure, and redirect handling that
// drains a stale in-flight fetch before restarting at the branch target.
module if_fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  pc_out,
  output logic [31:0] instruction,
  output logic        valid
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  // RUN: request outstanding; HOLD: word parked in buffer; DRAIN: dropping a stale fetch
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_HOLD  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;

  logic [1:0]    state,       state_n;
  logic [AW-1:0] fetch_pc,    fetch_pc_n;
  logic [AW-1:0] buf_pc,      buf_pc_n;
  logic [DW-1:0] buf_word,    buf_word_n;
  logic [AW-1:0] pend_pc,     pend_pc_n;
  logic [AW-1:0] pc_out_n;
  logic [DW-1:0] instruction_n;
  logic          valid_n;
  logic [AW-1:0] fetch_pc_inc;

  assign fetch_pc_inc = AW'(fetch_pc + AW'(1));

  // Request is masked during reset so memory never sees a fetch from a stale state
  assign imem_req  = !reset && (state != S_HOLD);
  assign imem_addr = fetch_pc;

  // State register and fetch datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      fetch_pc    <= RESET_PC;
      buf_pc      <= '0;
      buf_word    <= NOP_WORD;
      pend_pc     <= '0;
      pc_out      <= RESET_PC;
      instruction <= NOP_WORD;
      valid       <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      buf_pc      <= buf_pc_n;
      buf_word    <= buf_word_n;
      pend_pc     <= pend_pc_n;
      pc_out      <= pc_out_n;
      instruction <= instruction_n;
      valid       <= valid_n;
    end
  end

  // Next-state and next-output logic; redirect outranks stall and ack
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    buf_pc_n      = buf_pc;
    buf_word_n    = buf_word;
    pend_pc_n     = pend_pc;
    pc_out_n      = pc_out;
    instruction_n = instruction;
    valid_n       = valid;

    if (redirect) begin
      valid_n       = 1'b0;
      instruction_n = NOP_WORD;
      unique case (state)
        S_RUN: begin
          if (imem_ack) begin
            fetch_pc_n = redirect_pc;
            state_n    = S_RUN;
          end else begin
            pend_pc_n  = redirect_pc;
            state_n    = S_DRAIN;
          end
        end
        S_HOLD: begin
          fetch_pc_n = redirect_pc;
          state_n    = S_RUN;
        end
        S_DRAIN: begin
          // Latest target wins; if the stale word lands now, jump straight there
          pend_pc_n = redirect_pc;
          if (imem_ack) begin
            fetch_pc_n = redirect_pc;
            state_n    = S_RUN;
          end
        end
        default: state_n = S_RUN;
      endcase
    end else begin
      unique case (state)
        S_RUN: begin
          if (imem_ack) begin
            fetch_pc_n = fetch_pc_inc;
            if (stall) begin
              buf_word_n = imem_rdata;
              buf_pc_n   = fetch_pc;
              state_n    = S_HOLD;
            end else begin
              instruction_n = imem_rdata;
              pc_out_n      = fetch_pc;
              valid_n       = 1'b1;
            end
          end else if (!stall) begin
            valid_n       = 1'b0;
            instruction_n = NOP_WORD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instruction_n = buf_word;
            pc_out_n      = buf_pc;
            valid_n       = 1'b1;
            state_n       = S_RUN;
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            valid_n       = 1'b0;
            instruction_n = NOP_WORD;
          end
          if (imem_ack) begin
            fetch_pc_n = pend_pc;
            state_n    = S_RUN;
          end
        end
        default: state_n = S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: a stream-level fetch model predicts
// every cycle's request and registered outputs; a monitor compares them.
module tb_if_fetch_unit;

  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [7:0]  pc_out;
  logic [31:0] instruction;
  logic        valid;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .instruction(instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_out;
    bit          req;
    logic [7:0]  addr;
    bit          valid;
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: the fetch stream as sequential addresses with jumps
  logic [7:0]  m_addr    = RESET_PC;
  bit          m_stale   = 1'b0;
  logic [7:0]  m_target  = '0;
  bit          m_held    = 1'b0;
  logic [7:0]  m_held_pc = '0;
  bit          out_known = 1'b0;
  bit          e_valid   = 1'b0;
  logic [7:0]  e_pc      = RESET_PC;
  logic [31:0] e_instr   = NOP;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {a, ~a, 8'hA5, a ^ 8'h3C};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle of stimulus; pushes this cycle's expectation, then advances the model
  task automatic cyc(input bit rst, input bit a, input bit s, input bit r, input logic [7:0] t);
    exp_t e;
    bit   ack;
    bit   delivered;
    @(negedge clk);
    e.chk_out = out_known;
    e.req     = !rst && !m_held;
    e.addr    = m_addr;
    e.valid   = e_valid;
    e.pc      = e_pc;
    e.instr   = e_instr;
    q.push_back(e);

    ack         = a && !rst && !m_held;
    reset       = rst;
    imem_ack    = ack;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    imem_rdata  = ack ? word_of(imem_addr) : $urandom;

    delivered = 1'b0;
    if (rst) begin
      m_addr = RESET_PC; m_stale = 1'b0; m_held = 1'b0;
      e_valid = 1'b0; e_pc = RESET_PC; e_instr = NOP; out_known = 1'b1;
    end else if (r) begin
      e_valid = 1'b0; e_instr = NOP;
      if (m_held || ack) begin
        m_addr = t; m_stale = 1'b0; m_held = 1'b0;
      end else begin
        m_stale = 1'b1; m_target = t;
      end
    end else begin
      if (m_held) begin
        if (!s) begin
          e_valid = 1'b1; e_pc = m_held_pc; e_instr = word_of(m_held_pc);
          delivered = 1'b1; m_held = 1'b0;
        end
      end else if (ack) begin
        if (m_stale) begin
          m_addr = m_target; m_stale = 1'b0;
        end else begin
          if (s) begin
            m_held = 1'b1; m_held_pc = m_addr;
          end else begin
            e_valid = 1'b1; e_pc = m_addr; e_instr = word_of(m_addr);
            delivered = 1'b1;
          end
          m_addr = 8'(m_addr + 8'd1);
        end
      end
      if (!s && !delivered) begin
        e_valid = 1'b0; e_instr = NOP;
      end
    end
  endtask

  // Monitor: compares DUT request and registered outputs against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_req", 32'(imem_req), 32'(e.req));
        if (e.req) chk("imem_addr", 32'(imem_addr), 32'(e.addr));
        if (e.chk_out) begin
          chk("valid", 32'(valid), 32'(e.valid));
          chk("pc_out", 32'(pc_out), 32'(e.pc));
          chk("instruction", instruction, e.instr);
        end
      end
    end
  end

  initial begin
    // Reset, then zero-wait streaming from RESET_PC
    cyc(1, 0, 0, 0, 0); cyc(1, 1, 1, 1, 8'h33);
    repeat (5) cyc(0, 1, 0, 0, 0);
    // Ack delayed two cycles on address 05
    cyc(0, 1, 0, 1, 8'h05);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Stall on the ack of word 07, hold two cycles, release, resume at 08
    cyc(0, 1, 0, 1, 8'h07);
    cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    // Redirect to 40 while 10 is outstanding; stale ack two cycles later
    cyc(0, 1, 0, 1, 8'h10);
    cyc(0, 0, 0, 1, 8'h40); cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    // Last redirect wins during drain
    cyc(0, 0, 0, 1, 8'h50); cyc(0, 0, 0, 1, 8'h58); cyc(0, 0, 1, 1, 8'h5C);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    // Address wrap FF -> 00
    cyc(0, 1, 0, 1, 8'hFE);
    repeat (4) cyc(0, 1, 0, 0, 0);
    // Redirect together with stall while holding a word
    cyc(0, 1, 0, 1, 8'h20);
    cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 8'h60);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    // Reset mid-HOLD and mid-DRAIN
    cyc(0, 1, 1, 0, 0); cyc(1, 1, 1, 1, 8'h77);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'h90); cyc(1, 1, 0, 1, 8'h91);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 8,
          8'($urandom_range(0, 255)));
    end
    cyc(0, 1, 0, 0, 0);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, SHALL be the instruction value driven on bubbles and flushes.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  the fetch request to instruction memory.
REQ-006 imem_addr  output  8  the fetch address, equal to the internal fetch_pc.
REQ-007 imem_ack  input  1  memory has accepted the request; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  the instruction word returned by memory.
REQ-009 stall  input  1  the IF/ID stage cannot accept a new word this cycle.
REQ-010 redirect  input  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-011 redirect_pc  input  8  the redirect target address.
REQ-012 pc_out  output  8  address of the word on instruction, registered.
REQ-013 instruction  output  32  the fetched word presented to IF/ID, registered.
REQ-014 valid  output  1  instruction/pc_out hold a real fetched word, registered.

Function
REQ-015 The FSM SHALL have exactly three states: RUN (req outstanding), HOLD (word buffered, waiting on stall), DRAIN (discarding a stale in-flight fetch).
REQ-016 imem_req SHALL be 1 in RUN and DRAIN and 0 in HOLD and during reset.
REQ-017 While imem_req=1 and imem_ack=0, imem_addr SHALL remain constant.
REQ-018 In RUN with ack=1, stall=0, redirect=0: instruction<=imem_rdata, pc_out<=fetch_pc, valid<=1, fetch_pc<=fetch_pc+1; the FSM stays in RUN.
REQ-019 fetch_pc increment SHALL be modulo 256 (8'hFF+1 = 8'h00).
REQ-020 In RUN with ack=0, stall=0, redirect=0: valid<=0 and instruction<=NOP_WORD (bubble); pc_out SHALL hold.
REQ-021 With stall=1 and redirect=0, instruction, pc_out and valid SHALL hold their values in every state.
REQ-022 In RUN with ack=1, stall=1, redirect=0: imem_rdata and fetch_pc SHALL be captured into a one-entry buffer; fetch_pc<=fetch_pc+1; next state is HOLD.
REQ-023 In HOLD with stall=0, redirect=0: the buffered word and address SHALL load into instruction/pc_out with valid<=1; next state is RUN.
REQ-024 redirect=1 SHALL take priority over stall and ack: valid<=0, instruction<=NOP_WORD, the buffer is discarded, and pc_out holds.
REQ-025 A redirect in RUN with ack=1, or in HOLD, SHALL set fetch_pc<=redirect_pc with next state RUN, so the target is requested on the next cycle.
REQ-026 A redirect in RUN with ack=0 SHALL store redirect_pc as a pending target and move the FSM to DRAIN.
REQ-027 In DRAIN, the old address SHALL be held with req=1; on ack the data SHALL be dropped, fetch_pc<=pending target, and the FSM returns to RUN.
REQ-028 A redirect in DRAIN SHALL overwrite the pending target; the last redirect wins.
REQ-029 In DRAIN without a redirect, valid SHALL be 0 unless stall=1, in which case REQ-021 holds.
REQ-030 At most one word SHALL be buffered; no fetch SHALL be issued while in HOLD.

Reset
REQ-031 reset=1 SHALL set, at the next edge: state=RUN, fetch_pc=RESET_PC, pc_out=RESET_PC, instruction=NOP_WORD, valid=0, buffer empty, pending target cleared.
REQ-032 imem_req SHALL be 0 during any cycle with reset=1 and SHALL be 1 on the first cycle after reset deasserts.
REQ-033 Reset SHALL override redirect, stall and ack in any state, including mid-DRAIN and mid-HOLD; in-flight data SHALL be dropped.

Verification
REQ-034 Zero-wait memory, stall=0: reset then run 4 cycles -> imem_addr 00,01,02,03; outputs one cycle later with pc_out 00,01,02,03, valid=1.
REQ-035 Ack delayed 2 cycles on addr 05 -> imem_addr stays 05 for 3 cycles, valid=0 and instruction=NOP_WORD during the wait, then pc_out=05, valid=1.
REQ-036 stall=1 on the cycle word @07 is acked -> HOLD, imem_req=0, outputs unchanged; release stall -> pc_out=07 next cycle, then fetch of 08 resumes.
REQ-037 redirect to 8'h40 while addr 10 is outstanding (ack=0), ack two cycles later -> word @10 never appears with valid=1; next request address is 40.
REQ-038 fetch_pc=8'hFF with zero-wait memory -> next imem_addr=8'h00, pc_out=FF then 00.
REQ-039 redirect=1 and stall=1 in the same cycle while in HOLD -> valid=0 and instruction=NOP_WORD next cycle; the buffer is dropped and fetch restarts at redirect_pc.
